// File: rtl/chop_pkg.sv
// Shared types and helpers for the chop block: din/dout item layouts and the
// effective chunk-size rule (a chunk size of zero behaves as one).
package chop_pkg;

  localparam int DEF_TDIN    = 16;
  localparam int DEF_DIN_LVL = 1;
  localparam int DEF_CNT_W   = 16;

  typedef struct packed {
    logic [DEF_DIN_LVL-1:0] eot;
    logic [DEF_TDIN-1:0]    data;
  } din_t;

  typedef struct packed {
    logic [DEF_DIN_LVL:0] eot;
    logic [DEF_TDIN-1:0]  data;
  } dout_t;

  // Chunk sizes wider than 32 bits are not supported by this helper.
  function automatic int unsigned neff(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/chop_cnt.sv
// Item-within-chunk counter with chunk-end detect; advances only when an item
// is accepted downstream and restarts after every chunk end.
module chop_cnt
  import chop_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [CNT_W-1:0] n,
  input  logic             last_in,
  output logic [CNT_W-1:0] cnt,
  output logic             chunk_end
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_idx;

  always_comb begin
    last_idx  = CNT_W'(neff(32'(n)) - 1);
    chunk_end = last_in | (cnt_q == last_idx);
    cnt_d     = cnt_q;
    if (inc) begin
      cnt_d = chunk_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/chop.sv
// Adds one eot level below the din levels by cutting each innermost transaction
// into chunks of cfg items; fully combinational datapath, zero latency.
module chop
  import chop_pkg::*;
#(
  parameter int TDIN    = DEF_TDIN,
  parameter int DIN_LVL = DEF_DIN_LVL,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_vld_i,
  input  logic [DIN_LVL+TDIN-1:0]   din_dat_i,
  output logic                      din_rdy_o,
  input  logic                      cfg_vld_i,
  input  logic [CNT_W-1:0]          cfg_dat_i,
  output logic                      cfg_rdy_o,
  output logic                      dout_vld_o,
  output logic [DIN_LVL+TDIN:0]     dout_dat_o,
  input  logic                      dout_rdy_i
);

  logic             dout_hs;
  logic             last_in;
  logic             chunk_end;
  logic [CNT_W-1:0] cnt_unused;

  assign last_in = din_dat_i[TDIN];

  // dout valid never looks at dout ready, so no ready->valid loop exists.
  assign dout_vld_o = din_vld_i & cfg_vld_i;
  assign din_rdy_o  = dout_rdy_i & cfg_vld_i;
  assign dout_hs    = dout_vld_o & dout_rdy_i;
  assign cfg_rdy_o  = dout_hs & last_in;

  assign dout_dat_o = {din_dat_i[DIN_LVL+TDIN-1:TDIN], chunk_end, din_dat_i[TDIN-1:0]};

  chop_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (dout_hs),
    .n        (cfg_dat_i),
    .last_in  (last_in),
    .cnt      (cnt_unused),
    .chunk_end(chunk_end)
  );

endmodule

// File: tb/tb_chop.sv
// Directed bench for chop: a per-transaction item-position model feeds an
// expected queue that is checked on every downstream handshake.
module tb_chop;
  import chop_pkg::*;

  localparam int TDIN = 16;
  localparam int LVL  = 1;
  localparam int CW   = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              din_vld_i = 1'b0;
  logic [LVL+TDIN-1:0] din_dat_i = '0;
  logic              din_rdy_o;
  logic              cfg_vld_i = 1'b0;
  logic [CW-1:0]     cfg_dat_i = '0;
  logic              cfg_rdy_o;
  logic              dout_vld_o;
  logic [LVL+TDIN:0] dout_dat_o;
  logic              dout_rdy_i = 1'b1;

  int    checks = 0;
  int    errors = 0;
  int    cfg_hs = 0;
  logic  rand_rdy = 1'b0;
  dout_t exp_q[$];
  dout_t obs_q[$];
  dout_t ref_q[$];

  chop dut (
    .clk       (clk),
    .rst       (rst),
    .din_vld_i (din_vld_i),
    .din_dat_i (din_dat_i),
    .din_rdy_o (din_rdy_o),
    .cfg_vld_i (cfg_vld_i),
    .cfg_dat_i (cfg_dat_i),
    .cfg_rdy_o (cfg_rdy_o),
    .dout_vld_o(dout_vld_o),
    .dout_dat_o(dout_dat_o),
    .dout_rdy_i(dout_rdy_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    dout_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    dout_t d, e;
    if (!rst) begin
      chk("dout_vld_rel", 32'(dout_vld_o), 32'(din_vld_i & cfg_vld_i));
      chk("din_rdy_rel", 32'(din_rdy_o), 32'(dout_rdy_i & cfg_vld_i));
      if (dout_vld_o && dout_rdy_i) begin
        d = dout_dat_o;
        obs_q.push_back(d);
        if (cfg_vld_i && cfg_rdy_o) cfg_hs++;
        if (exp_q.size() == 0) begin
          chk("unexpected_item", 32'(d), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("dout_item", 32'(d), 32'(e));
          chk("cfg_rdy_last", 32'(cfg_rdy_o), 32'(e.eot[1]));
        end
      end else begin
        chk("cfg_rdy_idle", 32'(cfg_rdy_o), 32'h0);
      end
    end
  end

  // Model: item i of a len-item transaction ends a chunk when (i+1) is a
  // multiple of the effective size or when it is the last item.
  task automatic send_txn(input int n, input int len, input int base,
                          input int gap_at, input int stop_at);
    int    ne;
    int    cyc;
    din_t  di;
    dout_t e;
    ne = (n == 0) ? 1 : n;
    cfg_vld_i = 1'b1;
    cfg_dat_i = CW'(n);
    for (int i = 0; i < len; i++) begin
      if (i == stop_at) begin
        din_vld_i = 1'b0;
        return;
      end
      di.eot  = 1'(i == len - 1);
      di.data = TDIN'(base + i);
      din_dat_i = di;
      din_vld_i = 1'b1;
      if (i == gap_at) begin
        cfg_vld_i = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("gap_dout_vld", 32'(dout_vld_o), 32'h0);
          chk("gap_din_rdy", 32'(din_rdy_o), 32'h0);
          chk("gap_cnt", 32'(dut.u_cnt.cnt), 32'(i % ne));
        end
        @(posedge clk);
        #1;
        cfg_vld_i = 1'b1;
      end
      e.eot  = {1'(i == len - 1), 1'(((i + 1) % ne == 0) || (i == len - 1))};
      e.data = TDIN'(base + i);
      exp_q.push_back(e);
      cyc = 0;
      do begin
        @(posedge clk);
        cyc++;
      end while (!(din_vld_i && din_rdy_o) && cyc < 200);
      if (cyc >= 200) begin
        chk("handshake_timeout", 32'h0, 32'h1);
        din_vld_i = 1'b0;
        cfg_vld_i = 1'b0;
        return;
      end
      #1;
    end
    din_vld_i = 1'b0;
    cfg_vld_i = 1'b0;
  endtask

  task automatic masks(output logic [31:0] m0, output logic [31:0] m1);
    m0 = '0;
    m1 = '0;
    foreach (obs_q[k]) begin
      m0[k] = obs_q[k].eot[0];
      m1[k] = obs_q[k].eot[1];
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [31:0] m0, m1;
    #1;
    chk("rst_cnt", 32'(dut.u_cnt.cnt), 32'h0);
    chk("rst_dout_vld", 32'(dout_vld_o), 32'h0);
    chk("rst_din_rdy", 32'(din_rdy_o), 32'h0);
    chk("rst_cfg_rdy", 32'(cfg_rdy_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    obs_q.delete(); cfg_hs = 0;
    send_txn(3, 7, 'h100, -1, -1);
    settle();
    masks(m0, m1);
    chk("n3_count", 32'(obs_q.size()), 32'd7);
    chk("n3_eot0", m0, 32'b1100100);
    chk("n3_eot1", m1, 32'b1000000);
    chk("n3_cfg_hs", 32'(cfg_hs), 32'd1);

    obs_q.delete();
    send_txn(4, 8, 'h200, -1, -1);
    settle();
    masks(m0, m1);
    chk("n4_count", 32'(obs_q.size()), 32'd8);
    chk("n4_eot0", m0, 32'b10001000);
    chk("n4_cnt_after", 32'(dut.u_cnt.cnt), 32'h0);

    obs_q.delete();
    send_txn(0, 3, 'h300, -1, -1);
    settle();
    masks(m0, m1);
    chk("n0_eot0", m0, 32'b111);
    obs_q.delete();
    send_txn(1, 3, 'h310, -1, -1);
    settle();
    masks(m0, m1);
    chk("n1_eot0", m0, 32'b111);

    obs_q.delete();
    send_txn(5, 12, 'h400, -1, -1);
    settle();
    ref_q = obs_q;
    masks(m0, m1);
    chk("n5_eot0", m0, 32'b101000010000);
    obs_q.delete();
    rand_rdy = 1'b1;
    send_txn(5, 12, 'h400, -1, -1);
    rand_rdy = 1'b0;
    settle();
    chk("n5_rand_count", 32'(obs_q.size()), 32'(ref_q.size()));
    foreach (ref_q[k]) begin
      if (k < obs_q.size()) chk("n5_rand_seq", 32'(obs_q[k]), 32'(ref_q[k]));
    end

    obs_q.delete();
    send_txn(3, 5, 'h500, 2, -1);
    settle();
    masks(m0, m1);
    chk("gap_eot0", m0, 32'b10100);
    chk("gap_count", 32'(obs_q.size()), 32'd5);

    send_txn(4, 6, 'h600, -1, 2);
    cfg_vld_i = 1'b0;
    chk("pre_rst_cnt", 32'(dut.u_cnt.cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(dut.u_cnt.cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    obs_q.delete();
    send_txn(4, 4, 'h700, -1, -1);
    settle();
    masks(m0, m1);
    chk("post_rst_eot0", m0, 32'b1000);
    chk("post_rst_cnt", 32'(dut.u_cnt.cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
